// File: rtl/aux_int_conditioner.sv
// Push-button interrupt conditioner: synchronises and debounces active-low buttons,
// latches press events and presents a prioritised, maskable request with acknowledge.
module aux_int_conditioner #(
    parameter int NumSrc      = 3,
    parameter int DebounceCnt = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumSrc-1:0] btn_n,
    input  logic [NumSrc-1:0] mask,
    input  logic              ack,
    input  logic [2:0]        ack_id,
    input  logic              clr_ovf,
    output logic [NumSrc-1:0] pending,
    output logic [NumSrc-1:0] ovf,
    output logic              irq_req,
    output logic [2:0]        irq_id,
    output logic [NumSrc-1:0] stable_n
);
    localparam int CntW = $clog2(DebounceCnt + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

    logic [NumSrc-1:0] sync1_q;
    logic [NumSrc-1:0] sync2_q;
    logic [NumSrc-1:0] stable_q;
    logic [NumSrc-1:0] stable_d;
    logic [NumSrc-1:0] pending_q;
    logic [NumSrc-1:0] pending_d;
    logic [NumSrc-1:0] ovf_q;
    logic [NumSrc-1:0] ovf_d;
    logic [NumSrc-1:0] press_s;
    logic [NumSrc-1:0] ack_hit_s;
    logic [CntW-1:0]   cnt_q [NumSrc];
    logic [CntW-1:0]   cnt_d [NumSrc];
    logic              irq_req_s;
    logic [2:0]        irq_id_s;

    // Debounce: accept a new level once it has persisted for DebounceCnt cycles
    always_comb begin
        stable_d = stable_q;
        press_s  = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < NumSrc; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
                press_s[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Pending/overrun update; a press outranks an ack on the same source
    always_comb begin
        pending_d = pending_q;
        ovf_d     = clr_ovf ? '0 : ovf_q;
        ack_hit_s = '0;
        for (int i = 0; i < NumSrc; i++) begin
            ack_hit_s[i] = ack && (ack_id == 3'(i));
            if (press_s[i]) begin
                pending_d[i] = 1'b1;
                ovf_d[i]     = ovf_d[i] | (pending_q[i] & ~ack_hit_s[i]);
            end else if (ack_hit_s[i]) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Request encoder: scan downwards so the lowest unmasked index wins
    always_comb begin
        irq_id_s = 3'd0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            irq_id_s = (pending_q[i] && !mask[i]) ? 3'(i) : irq_id_s;
        end
        irq_req_s = |(pending_q & ~mask);
    end

    // State registers; synchronisers and stable levels reset to released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            stable_q  <= '1;
            pending_q <= '0;
            ovf_q     <= '0;
            for (int i = 0; i < NumSrc; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            for (int i = 0; i < NumSrc; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pending  = pending_q;
    assign ovf      = ovf_q;
    assign stable_n = stable_q;
    assign irq_req  = irq_req_s;
    assign irq_id   = irq_id_s;

endmodule
